// File: rtl/decoder_scan_pkg.sv
// -----------------------------------------------------------------------------
// decoder_scan_pkg
//   Shared definitions for decoder_scan_n: the external mode encoding on the
//   'mode' port, the internal FSM state set, and helpers that map between them.
//   No ports (package).
// -----------------------------------------------------------------------------
package decoder_scan_pkg;

    // Encoding of the 2-bit 'mode' input.
    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_SWEEP     = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_DIRECT     = 3'd0,
        ST_SCAN_UP    = 3'd1,
        ST_SCAN_DOWN  = 3'd2,
        ST_SWEEP_IDLE = 3'd3,
        ST_SWEEP_RUN  = 3'd4
    } state_e;

    // Mode a state belongs to; a mismatch with the 'mode' input is a mode change.
    function automatic mode_e mode_of_state(input state_e s);
        mode_e m;
        case (s)
            ST_SCAN_UP:                  m = MODE_SCAN_UP;
            ST_SCAN_DOWN:                m = MODE_SCAN_DOWN;
            ST_SWEEP_IDLE, ST_SWEEP_RUN: m = MODE_SWEEP;
            default:                     m = MODE_DIRECT;
        endcase
        return m;
    endfunction

    // State entered when switching into a mode; a sweep always starts out idle.
    function automatic state_e entry_state(input mode_e m);
        state_e s;
        case (m)
            MODE_SCAN_UP:   s = ST_SCAN_UP;
            MODE_SCAN_DOWN: s = ST_SCAN_DOWN;
            MODE_SWEEP:     s = ST_SWEEP_IDLE;
            default:        s = ST_DIRECT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/decoder_scan_n_onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//   Combinational SEL_W-to-2**SEL_W decoder with enable and selectable polarity.
//   Ports:
//     en  in   1               1: drive the addressed line active, 0: all inactive
//     a   in   SEL_W           address
//     y   out  2**SEL_W        decoded lines (one-cold when ACTIVE_LOW != 0)
// -----------------------------------------------------------------------------
module onehot_dec #(
    parameter int SEL_W      = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  en,
    input  logic [SEL_W-1:0]      a,
    output logic [2**SEL_W-1:0]   y
);

    logic [2**SEL_W-1:0] hot;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hot = '0;
        if (en) begin
            hot[a] = 1'b1;
        end
    end

    assign y = (ACTIVE_LOW != 0) ? ~hot : hot;

endmodule

// File: rtl/decoder_scan_n.sv
// -----------------------------------------------------------------------------
// decoder_scan_n
//   Registered 74138-style decoder with 74137-style address latch and a scan
//   sequencer (scan up, scan down, one-shot sweep) with per-position dwell.
//   Ports:
//     clk    in   1        rising-edge clock
//     rst    in   1        asynchronous active-high reset
//     g1     in   1        enable, active high
//     g2_n   in   2        enables, active low (any bit high disables)
//     le     in   1        address latch enable (direct mode)
//     sel    in   SEL_W    direct-mode address
//     mode   in   2        00 direct, 01 scan up, 10 scan down, 11 sweep
//     div    in   DIV_W    dwell cycles per position (0 behaves as 1)
//     start  in   1        sweep trigger, honoured only while idle
//     d      out  OUT_N    registered decoded outputs
//     idx    out  SEL_W    currently decoded index
//     valid  out  1        d carries an active selection
//     busy   out  1        sweep in progress
//     wrap   out  1        one-cycle pulse on scan wrap / sweep completion
// -----------------------------------------------------------------------------
module decoder_scan_n
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int ACTIVE_LOW = 1,
    parameter int DIV_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 g1,
    input  logic [1:0]           g2_n,
    input  logic                 le,
    input  logic [SEL_W-1:0]     sel,
    input  logic [1:0]           mode,
    input  logic [DIV_W-1:0]     div,
    input  logic                 start,
    output logic [2**SEL_W-1:0]  d,
    output logic [SEL_W-1:0]     idx,
    output logic                 valid,
    output logic                 busy,
    output logic                 wrap
);

    localparam int                OUT_N   = 2**SEL_W;
    localparam logic [SEL_W-1:0]  IDX_MAX = '1;
    localparam logic [OUT_N-1:0]  D_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   latch_q, latch_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [OUT_N-1:0]   d_q, dec_y;

    mode_e              mode_in;
    logic               en;
    logic [DIV_W-1:0]   term_cnt;
    logic               term_hit;

    assign mode_in  = mode_e'(mode);
    assign en       = g1 & ~|g2_n;
    // div = 0 dwells one cycle, same as div = 1.
    assign term_cnt = (div == '0) ? '0 : div - DIV_W'(1);
    // '>=' rather than '==' so a div lowered mid-dwell advances on the next edge.
    assign term_hit = (cnt_q >= term_cnt);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        latch_d = latch_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;

        if (mode_in != mode_of_state(state_q)) begin
            state_d = entry_state(mode_in);
            cnt_d   = '0;
            busy_d  = 1'b0;
            idx_d   = (state_d == ST_SCAN_DOWN) ? IDX_MAX : '0;
        end else begin
            case (state_q)
                ST_SCAN_UP, ST_SCAN_DOWN, ST_SWEEP_RUN: begin
                    // en low freezes both the dwell counter and the index.
                    if (en) begin
                        if (term_hit) begin
                            cnt_d = '0;
                            if (state_q == ST_SCAN_DOWN) begin
                                idx_d  = idx_q - SEL_W'(1);
                                wrap_d = (idx_q == '0);
                            end else begin
                                idx_d  = idx_q + SEL_W'(1);
                                wrap_d = (idx_q == IDX_MAX);
                                if (state_q == ST_SWEEP_RUN && idx_q == IDX_MAX) begin
                                    state_d = ST_SWEEP_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + DIV_W'(1);
                        end
                    end
                end
                ST_SWEEP_IDLE: begin
                    if (start) begin
                        state_d = ST_SWEEP_RUN;
                        idx_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Direct mode, including the entry edge: idx always follows the latch,
        // which is transparent to sel while le is high.
        if (state_d == ST_DIRECT) begin
            if (le) begin
                latch_d = sel;
                idx_d   = sel;
            end else begin
                idx_d   = latch_q;
            end
        end

        valid_d = en & (state_d != ST_SWEEP_IDLE);
    end

    // Decoding the next-state index lets d land on the same edge as idx/valid.
    onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .en (valid_d),
        .a  (idx_d),
        .y  (dec_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DIRECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            latch_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            d_q     <= D_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            d_q     <= dec_y;
        end
    end

    assign d     = d_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_n
//   Directed and randomized stimulus for decoder_scan_n (SEL_W=3, ACTIVE_LOW=1,
//   DIV_W=8) checked against a behavioural model of the decoder/scanner rules.
// -----------------------------------------------------------------------------
module tb_decoder_scan_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        g1;
    logic [1:0]  g2_n;
    logic        le;
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic [7:0]  div;
    logic        start;
    logic [7:0]  d;
    logic [2:0]  idx;
    logic        valid;
    logic        busy;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int  m_mode, m_idx, m_cnt, m_latch;
    bit  m_run, m_valid, m_wrap;

    decoder_scan_n #(.SEL_W(3), .ACTIVE_LOW(1), .DIV_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .g1    (g1),
        .g2_n  (g2_n),
        .le    (le),
        .sel   (sel),
        .mode  (mode),
        .div   (div),
        .start (start),
        .d     (d),
        .idx   (idx),
        .valid (valid),
        .busy  (busy),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_cnt = 0; m_latch = 0;
        m_run = 0; m_valid = 0; m_wrap = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as they stand.
    task automatic model_edge();
        bit en;
        int dwell;
        bit advance;
        en      = g1 && (g2_n == 2'b00);
        dwell   = (div == 0) ? 1 : int'(div);
        advance = 0;
        m_wrap  = 0;
        if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_cnt  = 0;
            m_run  = 0;
            m_idx  = (m_mode == 2) ? 7 : 0;
        end else if (m_mode == 3 && !m_run) begin
            if (start) begin
                m_run = 1; m_idx = 0; m_cnt = 0;
            end
        end else if (m_mode != 0 && en) begin
            if (m_cnt + 1 >= dwell) begin
                m_cnt   = 0;
                advance = 1;
            end else begin
                m_cnt++;
            end
        end
        if (advance) begin
            if (m_mode == 2) begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + 7) % 8;
            end else begin
                m_wrap = (m_idx == 7);
                if (m_mode == 3 && m_idx == 7) m_run = 0;
                m_idx  = (m_idx + 1) % 8;
            end
        end
        if (m_mode == 0) begin
            if (le) m_latch = int'(sel);
            m_idx = m_latch;
        end
        m_valid = en && !(m_mode == 3 && !m_run);
    endtask

    task automatic check_all(input string tag);
        logic [7:0] exp_d;
        exp_d = m_valid ? ~(8'h01 << m_idx) : 8'hFF;
        check({tag, ".d"},     32'(d),     32'(exp_d));
        check({tag, ".idx"},   32'(idx),   32'(m_idx));
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".busy"},  32'(busy),  32'(m_run));
        check({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
        if (valid) check({tag, ".onecold"}, 32'($countones(~d)), 32'd1);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    int wraps;
    int busy_cycles;
    int held_idx;

    initial begin
        rst = 1'b1; g1 = 1'b0; g2_n = 2'b00; le = 1'b0; sel = '0;
        mode = 2'b00; div = 8'd0; start = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset.d_ff", 32'(d), 32'hFF);
        @(negedge clk);
        rst = 1'b0;

        // 1: direct capture and hold.
        g1 = 1'b1; g2_n = 2'b00; le = 1'b1; sel = 3'd5;
        step("direct_le");
        check("direct.d_df", 32'(d), 32'hDF);
        le = 1'b0; sel = 3'd2;
        step("direct_hold");
        check("direct.hold_df", 32'(d), 32'hDF);

        // 2: gating by g2_n.
        g2_n = 2'b01;
        step("gate_off");
        check("gate_off.d_ff", 32'(d), 32'hFF);
        g2_n = 2'b00;
        step("gate_on");
        check("gate_on.d_df", 32'(d), 32'hDF);

        // 3: scan up with dwell 2, then dwell 0.
        mode = 2'b01; div = 8'd2;
        step("up_entry");
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            step("up_div2");
            if (wrap) wraps++;
        end
        check("up_div2.wrap_count", 32'(wraps), 32'd1);
        check("up_div2.idx_back0", 32'(idx), 32'd0);
        div = 8'd0;
        for (int i = 0; i < 10; i++) step("up_div0");

        // Randomized scanning with en/div disturbances in both directions.
        for (int i = 0; i < 200; i++) begin
            if (i == 100) mode = 2'b10;
            g1   = ($urandom_range(0, 7) != 0);
            g2_n = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 7) == 0) div = 8'($urandom_range(0, 4));
            step("scan_rand");
        end

        // 4: scan down dwell 1, then drop back to direct.
        g1 = 1'b1; g2_n = 2'b00; div = 8'd1; mode = 2'b00;
        step("to_direct");
        mode = 2'b10;
        step("down_entry");
        check("down_entry.idx7", 32'(idx), 32'd7);
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            step("down_div1");
            if (wrap) wraps++;
        end
        check("down.wrap_count", 32'(wraps), 32'd1);
        for (int i = 0; i < 3; i++) step("down_more");
        mode = 2'b00; le = 1'b0;
        step("down_to_direct");
        check("down_to_direct.idx_latch", 32'(idx), 32'd5);
        check("down_to_direct.wrap0", 32'(wrap), 32'd0);

        // 5: sweep with dwell 3, start held throughout.
        mode = 2'b11; div = 8'd3;
        step("sweep_entry");
        start = 1'b1;
        busy_cycles = 0;
        wraps = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) start = 1'b0;
            if (i == 5) start = 1'b1;
            if (i == 24) start = 1'b0;
            step("sweep_div3");
            if (busy) busy_cycles++;
            if (wrap) wraps++;
        end
        check("sweep.busy_cycles", 32'(busy_cycles), 32'd24);
        check("sweep.wrap_count", 32'(wraps), 32'd1);
        // Start held across completion: restart comes one edge after it.
        div = 8'd1; start = 1'b1;
        for (int i = 0; i < 12; i++) step("sweep_restart");
        start = 1'b0;

        // Randomized traffic across all modes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            g1    = ($urandom_range(0, 7) != 0);
            g2_n  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            le    = ($urandom_range(0, 3) == 0);
            sel   = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) div = 8'($urandom_range(0, 4));
            step("all_rand");
        end

        // 6: asynchronous reset between edges mid-sweep.
        g1 = 1'b1; g2_n = 2'b00; le = 1'b0; div = 8'd2; mode = 2'b11; start = 1'b0;
        step("pre_rst_a");
        start = 1'b1;
        step("pre_rst_b");
        start = 1'b0;
        for (int i = 0; i < 5; i++) step("pre_rst_run");
        check("pre_rst.busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.d_ff", 32'(d), 32'hFF);
        @(negedge clk);
        rst = 1'b0;

        // en-low freeze in scan up.
        mode = 2'b01; div = 8'd1;
        for (int i = 0; i < 3; i++) step("freeze_run");
        held_idx = m_idx;
        g1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("freeze");
            check("freeze.idx_held", 32'(idx), 32'(held_idx));
        end
        g1 = 1'b1;
        for (int i = 0; i < 3; i++) step("resume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
